// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit bitwise logic unit with a one-deep valid/ready output stage.
// Chain mode substitutes the previous result (accumulator) for operand B.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             chain,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] txn_cnt
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] result;
  logic             fire;

  // The output register is free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;

  // A clear in the same cycle as a chained command makes B read as zero.
  assign opnd_b = chain ? (clr ? '0 : acc) : b;

  always_comb begin
    // NOTE: default assigned before the case so no path leaves result unassigned (no latch).
    result = '0;
    unique case (op_e'(op))
      OP_NOT:  result = ~a;
      OP_AND:  result = a & opnd_b;
      OP_OR:   result = a | opnd_b;
      OP_NAND: result = ~(a & opnd_b);
      OP_NOR:  result = ~(a | opnd_b);
      OP_XOR:  result = a ^ opnd_b;
      OP_XNOR: result = ~(a ^ opnd_b);
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
      acc       <= '0;
      txn_cnt   <= '0;
    end else begin
      if (fire) begin
        out_valid <= 1'b1;
        y         <= result;
        zero      <= ~|result;
        parity    <= ^result;
        acc       <= result;
        txn_cnt   <= txn_cnt + CNT_W'(1);
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (clr)       acc       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed scenarios plus random traffic
// compared against a truth-table reference model; a CNT_W=2 instance covers counter wrap.
module tb_logic_gate_unit;

  localparam int W  = 8;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, chain, clr, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;

  logic          in_ready, out_valid, zero, parity;
  logic [W-1:0]  y;
  logic [CW-1:0] txn_cnt;

  logic          in_ready2, out_valid2, zero2, parity2;
  logic [W-1:0]  y2;
  logic [1:0]    txn_cnt2;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_y, m_acc;
  logic         m_ov;
  int unsigned  m_cnt;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .chain(chain), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .parity(parity), .txn_cnt(txn_cnt)
  );

  logic_gate_unit #(.WIDTH(W), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .op(op),
    .a(a), .b(b), .chain(chain), .clr(clr), .out_valid(out_valid2), .out_ready(out_ready),
    .y(y2), .zero(zero2), .parity(parity2), .txn_cnt(txn_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each op is a 2-input truth table indexed by {a_bit, b_bit}; nibble k belongs to op k.
  function automatic logic [W-1:0] gate(input logic [2:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] z);
    logic [31:0]  tables;
    logic [3:0]   tt;
    logic [W-1:0] r;
    tables = 32'hC961_7E83;
    tt = tables[32'(o) * 4 +: 4];
    r = '0;
    for (int i = 0; i < W; i++) r[i] = tt[{x[i], z[i]}];
    return r;
  endfunction

  task automatic model_reset();
    m_y = '0; m_acc = '0; m_ov = 1'b0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":out_valid"},  32'(out_valid),  32'(m_ov));
    check({tag, ":y"},          32'(y),          32'(m_y));
    check({tag, ":zero"},       32'(zero),       32'(m_y == '0));
    check({tag, ":parity"},     32'(parity),     32'($countones(m_y) % 2));
    check({tag, ":txn_cnt"},    32'(txn_cnt),    m_cnt % 65536);
    check({tag, ":txn_cnt_w2"}, 32'(txn_cnt2),   m_cnt % 4);
    check({tag, ":out_valid_w2"}, 32'(out_valid2), 32'(m_ov));
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic ch, input logic cl, input logic rdy);
    in_valid = v; op = o; a = aa; b = bb; chain = ch; clr = cl; out_ready = rdy;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle(input string tag);
    logic         fire;
    logic [W-1:0] opb;
    #1;
    check({tag, ":in_ready"}, 32'(in_ready), 32'(!m_ov || out_ready));
    fire = in_valid && (!m_ov || out_ready);
    @(posedge clk);
    #1;
    if (fire) begin
      opb   = chain ? (clr ? '0 : m_acc) : b;
      m_y   = gate(op, a, opb);
      m_acc = m_y;
      m_ov  = 1'b1;
      m_cnt++;
    end else begin
      if (out_ready) m_ov = 1'b0;
      if (clr) m_acc = '0;
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [63:0]  sweep_y;
    int unsigned  cnt_before;
    sweep_y = 64'hCA69_9621_B7DE_4835;
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
    model_reset();

    // Reset state
    #12;
    check_outputs("reset");
    check("reset:in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Truth sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'hCA, 8'h5C, 1'b0, 1'b0, 1'b1);
      cycle("sweep");
      check("sweep:y_const", 32'(y), 32'(sweep_y[i*8 +: 8]));
    end
    check("sweep:txn_cnt_const", 32'(txn_cnt), 32'd8);
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle("drain");

    // Chain sequence
    drive(1'b1, 3'd7, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1); cycle("chain0");
    check("chain0:y_const", 32'(y), 32'hF0);
    drive(1'b1, 3'd5, 8'hFF, 8'h33, 1'b1, 1'b0, 1'b1); cycle("chain1");
    check("chain1:y_const", 32'(y), 32'h0F);
    drive(1'b1, 3'd1, 8'h3C, 8'h55, 1'b1, 1'b0, 1'b1); cycle("chain2");
    check("chain2:y_const", 32'(y), 32'h0C);
    drive(1'b1, 3'd2, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1); cycle("chain_clr");
    check("chain_clr:y_const", 32'(y), 32'h00);
    check("chain_clr:zero_const", 32'(zero), 32'd1);
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1); cycle("drain");

    // Backpressure
    drive(1'b1, 3'd1, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0); cycle("bp_first");
    cnt_before = m_cnt;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_stall");
      check("bp_stall:in_ready_const", 32'(in_ready), 32'd0);
      check("bp_stall:y_const", 32'(y), 32'h0F);
      check("bp_stall:cnt_hold", 32'(txn_cnt), cnt_before);
    end
    out_ready = 1'b1; cycle("bp_release");
    check("bp_release:cnt_once", 32'(txn_cnt), cnt_before + 1);
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1); cycle("bp_drain");
    check("bp_drain:cnt_no_dup", 32'(txn_cnt), cnt_before + 1);

    // Simultaneous clr + fire with acc=AA
    drive(1'b1, 3'd7, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1); cycle("cf_load");
    drive(1'b1, 3'd5, 8'h0F, 8'hFF, 1'b1, 1'b1, 1'b1); cycle("cf_fire");
    check("cf_fire:y_const", 32'(y), 32'h0F);
    drive(1'b1, 3'd5, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1); cycle("cf_acc");
    check("cf_acc:y_const", 32'(y), 32'h0F);
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1); cycle("drain");

    // Async reset with a result pending under backpressure
    drive(1'b1, 3'd2, 8'h81, 8'h18, 1'b0, 1'b0, 1'b0); cycle("rst_pend");
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst:in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycle("post_rst");

    // Counter wrap on the CNT_W=2 instance: 1,2,3,0,1
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 3'd5, 8'(i), 8'h3C, 1'b0, 1'b0, 1'b1);
      cycle("wrap");
      check("wrap:cnt_w2_const", 32'(txn_cnt2), 32'(i % 4));
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
